// File: rtl/gray_updown_counter_pkg.sv
// Shared constants and the binary-to-Gray helper used by the counter and its bench.
package gray_pkg;
  localparam int MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin_to_gray(input logic [MAX_WIDTH-1:0] value);
    return value ^ (value >> 1);
  endfunction
endpackage

// File: rtl/gray_updown_counter_if.sv
// Control and status bundle of the Gray up/down counter.
interface gray_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] bin_o;
  logic [WIDTH-1:0] gray_o;
  logic             tc_o;
  logic             wrap_o;

  modport master (
    output en, up, load, load_gray,
    input  bin_o, gray_o, tc_o, wrap_o
  );

  modport slave (
    input  en, up, load, load_gray,
    output bin_o, gray_o, tc_o, wrap_o
  );
endinterface

// File: rtl/gray_updown_counter_gray_to_bin.sv
// Width-generic Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      acc    = acc ^ gray[j];
      bin[j] = acc;
    end
  end
endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter held in binary with a registered Gray copy, Gray parallel load,
// terminal-count flag, wrap pulse and optional saturation.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input logic                 clk,
  input logic                 rst,
  gray_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RESET_BIN  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;
  logic             at_tc;

  gray_to_bin_n #(.WIDTH(WIDTH)) u_decode (
    .gray (bus.load_gray),
    .bin  (load_bin)
  );

  assign at_tc = bus.up ? (bin_q == '1) : (bin_q == '0);

  // A step taken at terminal count is exactly the wrapping step.
  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    if (bus.load) begin
      next_bin = load_bin;
    end else if (bus.en) begin
      if (!(SATURATE && at_tc)) begin
        next_bin  = bus.up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        next_wrap = at_tc;
      end
    end
  end

  assign next_gray = bus.load ? bus.load_gray
                              : WIDTH'(bin_to_gray(MAX_WIDTH'(next_bin)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RESET_BIN;
      gray_q <= RESET_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      wrap_q <= next_wrap;
    end
  end

  assign bus.bin_o  = bin_q;
  assign bus.gray_o = gray_q;
  assign bus.tc_o   = at_tc;
  assign bus.wrap_o = wrap_q;
endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: vector table and corner sequences at WIDTH 4, random run at WIDTH 32.
module tb_gray_updown_counter;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_a = 1'b0;
  logic rst32 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 if (clk_run) clk = ~clk;

  gray_updown_counter_if #(.WIDTH(4))  if4();
  gray_updown_counter_if #(.WIDTH(4))  ifs();
  gray_updown_counter_if #(.WIDTH(32)) if32();

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(0)) dut4 (
    .clk(clk), .rst(rst_a), .bus(if4));
  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(0)) duts (
    .clk(clk), .rst(rst_a), .bus(ifs));
  gray_updown_counter #(.WIDTH(32), .SATURATE(1'b0), .RESET_VALUE(5)) dut32 (
    .clk(clk), .rst(rst32), .bus(if32));

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lg;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    logic       wrap;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] up_gray [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_decode(input logic [31:0] g);
    logic [31:0] b = '0;
    for (int k = 0; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic vec_t mk(input logic en, up, load, input logic [3:0] lg, bin, gray,
                              input logic tc, wrap);
    vec_t v;
    v.en = en; v.up = up; v.load = load; v.lg = lg;
    v.bin = bin; v.gray = gray; v.tc = tc; v.wrap = wrap;
    return v;
  endfunction

  task automatic set4(input logic en, up, load, input logic [3:0] lg);
    if4.en = en; if4.up = up; if4.load = load; if4.load_gray = lg;
  endtask

  task automatic sets(input logic en, up, load, input logic [3:0] lg);
    ifs.en = en; ifs.up = up; ifs.load = load; ifs.load_gray = lg;
  endtask

  initial begin
    logic [3:0]  prev_gray;
    logic [31:0] m, m_next;
    logic        w_next;
    logic [31:0] lg32;

    set4(1'b0, 1'b1, 1'b0, 4'h0);
    sets(1'b0, 1'b1, 1'b0, 4'h0);
    if32.en = 1'b0; if32.up = 1'b1; if32.load = 1'b0; if32.load_gray = '0;

    // Asynchronous reset with the clock stopped.
    #3 rst_a = 1'b1; rst32 = 1'b1;
    #1;
    chk("rst4_bin", if4.bin_o, 4'h0);
    chk("rst4_gray", if4.gray_o, 4'h0);
    chk("rst4_wrap", if4.wrap_o, 1'b0);
    chk("rst4_tc_up", if4.tc_o, 1'b0);
    chk("rst32_bin", if32.bin_o, 32'd5);
    chk("rst32_gray", if32.gray_o, 32'd7);
    #3 rst_a = 1'b0; rst32 = 1'b0;
    clk_run = 1'b1;
    cyc();

    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'h0, 4'(i + 1), up_gray[i], i == 14, i == 15));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'hD, 4'h9, 4'hD, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h8, 4'hF, 4'h8, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h5, 4'h6, 4'h5, 1'b0, 1'b0));

    prev_gray = 4'h0;
    foreach (vecs[i]) begin
      set4(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lg);
      cyc();
      chk($sformatf("vec%0d_bin", i), if4.bin_o, vecs[i].bin);
      chk($sformatf("vec%0d_gray", i), if4.gray_o, vecs[i].gray);
      chk($sformatf("vec%0d_tc", i), if4.tc_o, vecs[i].tc);
      chk($sformatf("vec%0d_wrap", i), if4.wrap_o, vecs[i].wrap);
      if (vecs[i].en && !vecs[i].load)
        chk($sformatf("vec%0d_hamming", i), $countones(if4.gray_o ^ prev_gray), 1);
      prev_gray = vecs[i].gray;
    end

    // Reset asserted mid-count discards the pending step.
    set4(1'b1, 1'b1, 1'b0, 4'h0);
    cyc();
    cyc();
    chk("pre_rst_bin", if4.bin_o, 4'h8);
    #2 rst_a = 1'b1;
    #1;
    chk("midrst_bin", if4.bin_o, 4'h0);
    chk("midrst_gray", if4.gray_o, 4'h0);
    cyc();
    chk("rst_held_bin", if4.bin_o, 4'h0);
    rst_a = 1'b0;
    cyc();
    chk("post_rst_bin", if4.bin_o, 4'h1);
    chk("post_rst_gray", if4.gray_o, 4'h1);
    set4(1'b0, 1'b1, 1'b0, 4'h0);

    // Saturating instance: clamp at all-ones and at zero.
    sets(1'b0, 1'b1, 1'b1, 4'h8);
    cyc();
    chk("sat_load_bin", ifs.bin_o, 4'hF);
    sets(1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("sat_up%0d_bin", i), ifs.bin_o, 4'hF);
      chk($sformatf("sat_up%0d_gray", i), ifs.gray_o, 4'h8);
      chk($sformatf("sat_up%0d_wrap", i), ifs.wrap_o, 1'b0);
      chk($sformatf("sat_up%0d_tc", i), ifs.tc_o, 1'b1);
    end
    sets(1'b1, 1'b0, 1'b0, 4'h0);
    cyc();
    chk("sat_down_bin", ifs.bin_o, 4'hE);
    chk("sat_down_gray", ifs.gray_o, 4'h9);
    sets(1'b0, 1'b0, 1'b1, 4'h0);
    cyc();
    sets(1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk($sformatf("sat_lo%0d_bin", i), ifs.bin_o, 4'h0);
      chk($sformatf("sat_lo%0d_wrap", i), ifs.wrap_o, 1'b0);
      chk($sformatf("sat_lo%0d_tc", i), ifs.tc_o, 1'b1);
    end
    sets(1'b1, 1'b1, 1'b0, 4'h0);
    cyc();
    chk("sat_lo_up_gray", ifs.gray_o, 4'h1);
    sets(1'b0, 1'b1, 1'b0, 4'h0);

    // Random run on the 32-bit instance against an arithmetic model.
    m = 32'd5;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 3))
        0: lg32 = $urandom;
        1: lg32 = 32'h8000_0000;
        2: lg32 = 32'h0000_0000;
        default: lg32 = 32'h8000_0001;
      endcase
      if32.load = ($urandom_range(0, 7) == 0);
      if32.en = ($urandom_range(0, 3) != 0);
      if32.up = 1'($urandom_range(0, 1));
      if32.load_gray = lg32;
      w_next = 1'b0;
      if (if32.load) begin
        m_next = ref_decode(lg32);
      end else if (if32.en) begin
        if (if32.up) begin
          w_next = (m == 32'hFFFF_FFFF);
          m_next = m + 32'd1;
        end else begin
          w_next = (m == 32'd0);
          m_next = m - 32'd1;
        end
      end else begin
        m_next = m;
      end
      if (i == 5000) begin
        #2 rst32 = 1'b1;
        #1;
        chk("r32_rst_bin", if32.bin_o, 32'd5);
        chk("r32_rst_gray", if32.gray_o, 32'd7);
        chk("r32_rst_wrap", if32.wrap_o, 1'b0);
        cyc();
        chk("r32_rst_held_bin", if32.bin_o, 32'd5);
        rst32 = 1'b0;
        m = 32'd5;
        continue;
      end
      cyc();
      m = m_next;
      chk("r32_bin", if32.bin_o, m);
      chk("r32_gray", if32.gray_o, bin_to_gray(m));
      chk("r32_wrap", if32.wrap_o, w_next);
      chk("r32_tc", if32.tc_o, if32.up ? (m == 32'hFFFF_FFFF) : (m == 32'd0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_updown_counter.md
# gray_updown_counter

Parametrised up/down counter that keeps its state in binary and presents both the binary value and the reflected-binary Gray code every cycle, with Gray-coded parallel load, terminal-count flag, wrap pulse and an optional saturating mode. Next-generation Gray block for the logic library, used as pointer/position source where single-bit-change outputs are required. Loaded Gray values are decoded with a width-generic Gray-to-binary converter.

## Interface

Parameters:
- WIDTH, 8, counter width in bits; legal 2..32
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at all-ones (up) / zero (down)
- RESET_VALUE, 0, binary value loaded on reset; must fit in WIDTH bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; one step per cycle while high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  parallel load request
- load_gray  in  WIDTH  Gray-coded value to load
- bin_o  out  WIDTH  registered binary count
- gray_o  out  WIDTH  registered Gray count, always bin_o ^ (bin_o >> 1)
- tc_o  out  1  terminal count: bin_o all-ones when up=1, bin_o zero when up=0 (combinational on up)
- wrap_o  out  1  registered one-cycle pulse after a wrapping step

## Operation

- Priority per edge: load > en > hold.
- load=1: bin_o <= gray_to_bin_n(load_gray); gray_o <= load_gray; wrap_o <= 0; en and up ignored that cycle.
- en=1, load=0, SATURATE=0: up=1 -> bin_o <= bin_o+1 mod 2^WIDTH; up=0 -> bin_o-1 mod 2^WIDTH. gray_o follows. wrap_o <= 1 iff step was all-ones->0 (up) or 0->all-ones (down), else 0.
- en=1, load=0, SATURATE=1: step as above except at terminal count: state holds, wrap_o stays 0.
- en=0, load=0: hold; wrap_o <= 0.
- Gray encoding of next state computed from next binary value, registered together: gray_o and bin_o never disagree in any cycle.
- Every enabled non-saturated step changes gray_o in exactly one bit; loads may change any number.
- tc_o used for cascading: downstream enable = en & tc_o.
- No internal state beyond bin_o/gray_o/wrap_o registers.

## Timing

- Reset: asserted asynchronously, takes effect without clock: bin_o = RESET_VALUE, gray_o = RESET_VALUE ^ (RESET_VALUE >> 1), wrap_o = 0. tc_o then reflects reset state and up.
- Reset mid-count or mid-load: discards the in-flight step; first update after deassertion occurs on the first rising edge with rst low.
- Latency: load or step visible on outputs 1 cycle after the sampling edge; wrap_o coincides with the wrapped value.
- Throughput: one step or load per cycle; back-to-back loads allowed.
- tc_o: combinational from registered bin_o and live up; no clock latency.
- Load decode path is WIDTH-1 XOR levels deep (prefix XOR); acceptable at WIDTH 32 for library clock targets.

## Structure

- Package gray_pkg: MAX_WIDTH = 32 constant; function bin_to_gray(value) = value ^ (value >> 1); used by counter and bench.
- Sub-module gray_to_bin_n (parameter WIDTH, combinational): bin[WIDTH-1] = gray[WIDTH-1]; bin[j] = gray[j] ^ bin[j+1] for j down to 0. Instantiated once on load_gray.
- Counter top holds the three registers, next-state mux and tc/wrap logic.

## Test plan

- WIDTH=4, RESET_VALUE=0: assert rst with no clock -> bin_o=0, gray_o=0, wrap_o=0 immediately; up=1 gives tc_o=0.
- WIDTH=4, up=1, en=1 for 16 cycles from 0 -> gray_o 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; tc_o high at bin F; wrap_o pulses exactly once with bin_o=0; each step Hamming distance 1.
- WIDTH=4, up=0, en=1 from 0 -> bin_o=F, gray_o=8, wrap_o=1 for one cycle, then bin_o=E, gray_o=9, wrap_o=0.
- WIDTH=4, load=1, en=1, load_gray=D -> next cycle bin_o=9, gray_o=D, wrap_o=0 (load wins over count).
- WIDTH=4, SATURATE=1, at bin_o=F, up=1, en=1 for 3 cycles -> bin_o stays F, gray_o stays 8, wrap_o never asserts, tc_o stays 1; up=0 then steps to E.
- WIDTH=32, RESET_VALUE=5, random load/en/up for 10k cycles, rst pulsed asynchronously mid-run -> gray_o == bin_to_gray(bin_o) every cycle; after rst bin_o=5, gray_o=7.
